// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// flappy_pkg : game state encoding, collision geometry and BCD digit width
// Revision   : 1.0
// ============================================================================
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_LOST   = 2'd0,
    ST_READY  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_PAUSED = 2'd3
  } game_state_t;

  // Screen-space geometry; all collision arithmetic is 12-bit signed.
  localparam logic signed [11:0] c_pipe_left_base = 12'sd439;
  localparam logic signed [11:0] c_cy_base        = 12'sd480;
  localparam logic signed [11:0] c_bird_left      = 12'sd244;
  localparam logic signed [11:0] c_bird_right     = 12'sd284;
  localparam logic signed [11:0] c_pipe_width     = 12'sd50;
  localparam logic signed [11:0] c_bird_half      = 12'sd20;
  localparam logic signed [11:0] c_gap_top        = 12'sd75;
  localparam logic signed [11:0] c_gap_bottom     = 12'sd215;

  localparam int BCD_W = 4;

endpackage
`default_nettype wire

// File: rtl/flappy_game_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// btn_edge : two-flop synchroniser followed by a rising-edge detector
// Revision : 1.0
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn};
      r_prev <= r_sync[1];
    end
  end

  assign rise = r_sync[1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/flappy_game_ctrl.sv
`default_nettype none
// ============================================================================
// flappy_game_ctrl : game state machine, pipe scrolling, collision and score
// Revision         : 1.0
// ============================================================================
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES    = 2,
  parameter int PIPE_TRAVEL  = 345,
  parameter int SCORE_DIGITS = 2,
  parameter int INIT_GAP     = 100
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            tick,
  input  logic                            jump_btn,
  input  logic                            pause_btn,
  input  logic                            rst_btn,
  input  logic [10:0]                     bird_y,
  input  logic [7:0]                      rand_gap,
  output logic [1:0]                      state,
  output logic [9:0]                      pipe_pos,
  output logic [8*NUM_PIPES-1:0]          pipe_gap,
  output logic [BCD_W*SCORE_DIGITS-1:0]   score,
  output logic [BCD_W*SCORE_DIGITS-1:0]   high_score,
  output logic                            bird_run,
  output logic                            hit
);

  localparam int          SW         = BCD_W * SCORE_DIGITS;
  localparam logic [9:0]  c_travel   = 10'(PIPE_TRAVEL);
  localparam logic [7:0]  c_init_gap = 8'(INIT_GAP);

  // Reset asserts immediately but releases only on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic w_jump, w_pause, w_rst;

  btn_edge u_jump  (.clk(clk), .rst_n(w_rst_n), .btn(jump_btn),  .rise(w_jump));
  btn_edge u_pause (.clk(clk), .rst_n(w_rst_n), .btn(pause_btn), .rise(w_pause));
  btn_edge u_rst   (.clk(clk), .rst_n(w_rst_n), .btn(rst_btn),   .rise(w_rst));

  game_state_t     r_state;
  logic [9:0]      r_pipe_pos;
  logic [7:0]      r_gap [NUM_PIPES];
  logic [SW-1:0]   r_score;
  logic [SW-1:0]   r_high;
  logic            r_bird_run;
  logic            r_hit;

  logic signed [11:0] w_pipe_left, w_cy, w_gap0;
  logic               w_h_overlap, w_v_hit, w_crash;

  assign w_pipe_left = c_pipe_left_base - $signed({2'b00, r_pipe_pos});
  assign w_cy        = c_cy_base - $signed({1'b0, bird_y});
  assign w_gap0      = $signed({4'b0000, r_gap[0]});
  assign w_h_overlap = (c_bird_right > w_pipe_left) && (c_bird_left < w_pipe_left + c_pipe_width);
  assign w_v_hit     = (w_cy - c_bird_half < w_gap0 + c_gap_top) ||
                       (w_cy + c_bird_half > w_gap0 + c_gap_bottom);
  assign w_crash     = (w_h_overlap && w_v_hit) || (bird_y == 11'd0);

  // BCD increment that holds at all nines.
  logic [SW-1:0] w_score_inc;
  logic          w_score_max;
  logic          w_carry;

  always_comb begin
    w_score_inc = r_score;
    w_score_max = 1'b1;
    w_carry     = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (r_score[BCD_W*i +: BCD_W] != 4'd9) w_score_max = 1'b0;
      if (w_carry) begin
        if (r_score[BCD_W*i +: BCD_W] == 4'd9) begin
          w_score_inc[BCD_W*i +: BCD_W] = 4'd0;
        end else begin
          w_score_inc[BCD_W*i +: BCD_W] = r_score[BCD_W*i +: BCD_W] + 4'd1;
          w_carry = 1'b0;
        end
      end
    end
    if (w_score_max) w_score_inc = r_score;
  end

  logic w_to_ready;
  assign w_to_ready = w_rst && ((r_state == ST_LOST) || (r_state == ST_PAUSED && !w_pause));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_READY;
      r_pipe_pos <= '0;
      r_score    <= '0;
      r_hit      <= 1'b0;
      r_bird_run <= 1'b1;
      for (int i = 0; i < NUM_PIPES; i++) r_gap[i] <= c_init_gap;
    end else begin
      r_hit <= 1'b0;
      if (w_to_ready) begin
        r_state    <= ST_READY;
        r_pipe_pos <= '0;
        r_score    <= '0;
        r_bird_run <= 1'b1;
        for (int i = 0; i < NUM_PIPES; i++) r_gap[i] <= c_init_gap;
      end else begin
        case (r_state)
          ST_READY: if (w_jump) r_state <= ST_PLAY;
          ST_PLAY: begin
            if (w_pause) begin
              r_state    <= ST_PAUSED;
              r_bird_run <= 1'b0;
            end else if (tick) begin
              // Collision is judged on the pre-move position and beats a wrap.
              if (w_crash) begin
                r_state    <= ST_LOST;
                r_hit      <= 1'b1;
                r_bird_run <= 1'b0;
              end else if (r_pipe_pos < c_travel) begin
                r_pipe_pos <= r_pipe_pos + 10'd1;
              end else begin
                r_pipe_pos <= '0;
                for (int i = 0; i < NUM_PIPES - 1; i++) r_gap[i] <= r_gap[i+1];
                r_gap[NUM_PIPES-1] <= rand_gap;
                r_score <= w_score_inc;
              end
            end
          end
          ST_PAUSED: begin
            if (w_pause) begin
              r_state    <= ST_PLAY;
              r_bird_run <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)              r_high <= '0;
    else if (r_score > r_high) r_high <= r_score;
  end

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_gap
    assign pipe_gap[8*i +: 8] = r_gap[i];
  end

  assign state      = r_state;
  assign pipe_pos   = r_pipe_pos;
  assign score      = r_score;
  assign high_score = r_high;
  assign bird_run   = r_bird_run;
  assign hit        = r_hit;

endmodule
`default_nettype wire
